uart_bus_sequencer: RTL and testbench

- Parametrised bus-master sequencer for the UART register window.
- Accepts a command (direction, start register index, access count) and issues back-to-back bus read or write strobes. Addresses walk the register map with wrap-around.
- Write data is pulled from a valid/ready stream; read data is pushed out as one-cycle pulses.
- Adds per-access retry on bus_error, a sticky error state, and a done pulse.

---
 rtl/uart_bus_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_uart_bus_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_sequencer.sv
// Bus-master sequencer for the UART register window: walks registers with wrap-around,
// streams write data in and read data out, retries failed accesses, latches a sticky error.
module uart_bus_sequencer #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                NUM_REGS    = 5,
   parameter int                ADDR_STRIDE = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                CNT_W       = 8,
   parameter int                MAX_RETRY   = 3
) (
   input  logic                        clk,
   input  logic                        nReset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [$clog2(NUM_REGS)-1:0] cmd_start_idx,
   input  logic [CNT_W-1:0]            cmd_count,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   output logic [DATA_W-1:0]           rd_data,
   output logic                        rd_valid,
   output logic [ADDR_W-1:0]           bus_addr,
   output logic                        bus_ren,
   output logic                        bus_wen,
   output logic [DATA_W-1:0]           bus_wdata,
   input  logic [DATA_W-1:0]           bus_rdata,
   input  logic                        bus_ready,
   input  logic                        bus_error,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   input  logic                        err_clear
);

   localparam int IDX_W   = $clog2(NUM_REGS);
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REGS - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
   localparam logic [ADDR_W-1:0]  STRIDE_A  = ADDR_W'(ADDR_STRIDE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_ERROR
   } state_e;

   state_e              state_q,     state_d;
   logic                write_q,     write_d;
   logic [IDX_W-1:0]    idx_q,       idx_d;
   logic [CNT_W-1:0]    remain_q,    remain_d;
   logic [RETRY_W-1:0]  retry_q,     retry_d;
   logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
   logic                bus_ren_q,   bus_ren_d;
   logic                bus_wen_q,   bus_wen_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic [DATA_W-1:0]   rd_data_q,   rd_data_d;
   logic                rd_valid_q,  rd_valid_d;
   logic                done_q,      done_d;
   logic                err_q,       err_d;

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign wr_ready  = (state_q == S_FETCH) && wr_valid;
   assign bus_addr  = bus_addr_q;
   assign bus_ren   = bus_ren_q;
   assign bus_wen   = bus_wen_q;
   assign bus_wdata = bus_wdata_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
   assign err       = err_q;

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      idx_d       = idx_q;
      remain_d    = remain_q;
      retry_d     = retry_q;
      bus_addr_d  = bus_addr_q;
      bus_ren_d   = bus_ren_q;
      bus_wen_d   = bus_wen_q;
      bus_wdata_d = bus_wdata_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      done_d      = 1'b0;
      err_d       = err_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               write_d  = cmd_write;
               idx_d    = (cmd_start_idx > LAST_IDX) ? '0 : cmd_start_idx;
               remain_d = cmd_count;
               retry_d  = '0;
               if (cmd_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = cmd_write ? S_FETCH : S_ISSUE;
               end
            end
         end

         S_FETCH: begin
            if (wr_valid) begin
               bus_wdata_d = wr_data;
               state_d     = S_ISSUE;
            end
         end

         S_ISSUE: begin
            bus_addr_d = BASE_ADDR + STRIDE_A * ADDR_W'(idx_q);
            bus_ren_d  = !write_q;
            bus_wen_d  = write_q;
            state_d    = S_WAIT;
         end

         S_WAIT: begin
            // bus_error wins over bus_ready; a retry reuses the held address and data
            if (bus_error) begin
               bus_ren_d = 1'b0;
               bus_wen_d = 1'b0;
               if (retry_q < RETRY_LIM) begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = S_ISSUE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_ERROR;
               end
            end else if (bus_ready) begin
               bus_ren_d = 1'b0;
               bus_wen_d = 1'b0;
               retry_d   = '0;
               if (!write_q) begin
                  rd_data_d  = bus_rdata;
                  rd_valid_d = 1'b1;
               end
               remain_d = remain_q - CNT_W'(1);
               idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
               if (remain_q == CNT_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = write_q ? S_FETCH : S_ISSUE;
               end
            end
         end

         S_ERROR: begin
            if (err_clear) begin
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q     <= S_IDLE;
         write_q     <= 1'b0;
         idx_q       <= '0;
         remain_q    <= '0;
         retry_q     <= '0;
         bus_addr_q  <= BASE_ADDR;
         bus_ren_q   <= 1'b0;
         bus_wen_q   <= 1'b0;
         bus_wdata_q <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         idx_q       <= idx_d;
         remain_q    <= remain_d;
         retry_q     <= retry_d;
         bus_addr_q  <= bus_addr_d;
         bus_ren_q   <= bus_ren_d;
         bus_wen_q   <= bus_wen_d;
         bus_wdata_q <= bus_wdata_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Directed-plus-random bench for uart_bus_sequencer; the bench plays the bus slave and the
// write stream source, and predicts addresses, data, done and error behaviour from the rules.
module tb_uart_bus_sequencer;

   localparam int NR   = 5;
   localparam int STR  = 4;
   localparam int BASE = 0;
   localparam int MAXR = 3;

   logic        clk = 1'b0;
   logic        nReset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [2:0]  cmd_start_idx;
   logic [7:0]  cmd_count;
   logic [31:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [31:0] bus_addr;
   logic        bus_ren, bus_wen;
   logic [31:0] bus_wdata, bus_rdata;
   logic        bus_ready, bus_error;
   logic        busy, done, err, err_clear;

   int total = 0;
   int bad   = 0;

   uart_bus_sequencer #(
      .ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .ADDR_STRIDE(STR),
      .BASE_ADDR(32'(BASE)), .CNT_W(8), .MAX_RETRY(MAXR)
   ) dut (
      .clk(clk), .nReset(nReset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_start_idx(cmd_start_idx), .cmd_count(cmd_count),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .bus_addr(bus_addr), .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_error(bus_error),
      .busy(busy), .done(done), .err(err), .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_addr(input int start, input int k);
      return 32'(BASE + ((start + k) % NR) * STR);
   endfunction

   task automatic send_cmd(input bit we, input logic [2:0] idx, input logic [7:0] cnt);
      chk("cmd_ready", cmd_ready, 1);
      cmd_valid = 1; cmd_write = we; cmd_start_idx = idx; cmd_count = cnt;
      step();
      cmd_valid = 0; cmd_write = 1'($urandom); cmd_start_idx = 3'($urandom); cmd_count = 8'($urandom);
      chk("busy_cmd", busy, cnt != 0);
      chk("done_cmd", done, cnt == 0);
   endtask

   task automatic feed(input logic [31:0] d, input int dly);
      wr_valid = 0;
      repeat (dly) begin
         chk("fetch_stall_wen", bus_wen, 0);
         chk("fetch_stall_rdy", wr_ready, 0);
         wr_data = $urandom;
         step();
      end
      wr_valid = 1; wr_data = d;
      #1;
      chk("wr_ready", wr_ready, 1);
      step();
      wr_valid = 0; wr_data = $urandom;
      chk("wr_ready_pulse", wr_ready, 0);
   endtask

   // One bus attempt: wait for the strobe, check it, hold for lat cycles, then answer.
   task automatic serve(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input bit fail, input bit both, input bit last,
                        input logic [31:0] rdat);
      int n = 0;
      while (!(bus_ren || bus_wen) && n < 20) begin
         chk("wr_ready_issue", wr_ready, 0);
         step();
         n++;
      end
      chk("strobe_timeout", n < 20, 1);
      chk("strobe_wen", bus_wen, we);
      chk("strobe_ren", bus_ren, !we);
      chk("bus_addr", bus_addr, addr);
      if (we) chk("bus_wdata", bus_wdata, wd);
      repeat (lat) begin
         step();
         chk("hold_strobe", bus_ren | bus_wen, 1);
         chk("hold_addr", bus_addr, addr);
      end
      bus_rdata = rdat; bus_error = fail; bus_ready = !fail || both;
      step();
      bus_error = 0; bus_ready = 0; bus_rdata = $urandom;
      chk("strobe_drop", bus_ren | bus_wen, 0);
      chk("wr_ready_quiet", wr_ready, 0);
      if (!fail) begin
         chk("rd_valid", rd_valid, !we);
         if (!we) chk("rd_data", rd_data, rdat);
         chk("done", done, last);
         chk("busy_after", busy, !last);
      end else begin
         chk("rd_valid_err", rd_valid, 0);
         chk("done_err", done, 0);
      end
   endtask

   task automatic run_cmd(input bit we, input logic [2:0] idx, input logic [7:0] cnt,
                          input int maxerr, input int maxlat);
      int eff = (int'(idx) >= NR) ? 0 : int'(idx);
      send_cmd(we, idx, cnt);
      for (int k = 0; k < int'(cnt); k++) begin
         logic [31:0] a  = model_addr(eff, k);
         logic [31:0] wd = $urandom;
         int nerr = $urandom_range(0, maxerr);
         if (we) feed(wd, $urandom_range(0, 3));
         for (int e = 0; e < nerr; e++)
            serve(we, a, wd, $urandom_range(0, maxlat), 1, 1'($urandom_range(0, 1)), 0, $urandom);
         serve(we, a, wd, $urandom_range(0, maxlat), 0, 0, k == int'(cnt) - 1, $urandom);
      end
      step();
      chk("done_pulse_end", done, 0);
      chk("rd_valid_pulse_end", rd_valid, 0);
      chk("err_clean", err, 0);
   endtask

   initial begin
      logic [31:0] w0, w1;
      int dcnt, scnt;
      nReset = 0; cmd_valid = 0; cmd_write = 0; cmd_start_idx = '0; cmd_count = '0;
      wr_data = '0; wr_valid = 0; bus_rdata = '0; bus_ready = 0; bus_error = 0; err_clear = 0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ren", bus_ren, 0);
      chk("rst_wen", bus_wen, 0);
      chk("rst_addr", bus_addr, 32'(BASE));
      chk("rst_wdata", bus_wdata, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_wr_ready", wr_ready, 0);
      nReset = 1;
      step();

      // read from idx 3, four accesses, wrapping 12,16,0,4
      run_cmd(0, 3'd3, 8'd4, 0, 0);

      // write two words, first delayed 5 cycles
      send_cmd(1, 3'd4, 8'd2);
      w0 = $urandom; w1 = $urandom;
      feed(w0, 5);
      serve(1, model_addr(4, 0), w0, 1, 0, 0, 0, '0);
      feed(w1, 2);
      serve(1, model_addr(4, 1), w1, 0, 0, 0, 1, '0);
      step();
      chk("wr_done_end", done, 0);

      // two errors (second with ready high too), then success; no extra wr_ready
      send_cmd(1, 3'd1, 8'd1);
      w0 = $urandom;
      feed(w0, 0);
      wr_valid = 1; wr_data = $urandom;
      serve(1, model_addr(1, 0), w0, 0, 1, 0, 0, '0);
      serve(1, model_addr(1, 0), w0, 1, 1, 1, 0, '0);
      serve(1, model_addr(1, 0), w0, 0, 0, 0, 1, '0);
      wr_valid = 0;
      chk("retry_err_low", err, 0);
      step();

      // err_clear outside ERROR does nothing
      err_clear = 1;
      step();
      err_clear = 0;
      chk("errclr_idle_err", err, 0);
      chk("errclr_idle_ready", cmd_ready, 1);

      // four consecutive errors -> ERROR
      send_cmd(0, 3'd2, 8'd2);
      for (int e = 0; e <= MAXR; e++)
         serve(0, model_addr(2, 0), '0, 0, 1, 1'($urandom_range(0, 1)), 0, $urandom);
      chk("error_err", err, 1);
      chk("error_busy", busy, 1);
      chk("error_cmd_ready", cmd_ready, 0);
      cmd_valid = 1; cmd_write = 0; cmd_count = 8'd0;
      dcnt = 0; scnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         dcnt += int'(done);
         scnt += int'(bus_ren | bus_wen);
      end
      cmd_valid = 0;
      chk("error_no_done", dcnt, 0);
      chk("error_no_strobe", scnt, 0);
      chk("error_sticky", err, 1);
      err_clear = 1;
      step();
      err_clear = 0;
      chk("clear_err", err, 0);
      chk("clear_cmd_ready", cmd_ready, 1);
      chk("clear_busy", busy, 0);
      chk("clear_no_done", done, 0);

      // randomized commands against the model
      for (int i = 0; i < 10; i++)
         run_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 6)), 2, 2);

      // asynchronous reset in the middle of a write access
      send_cmd(1, 3'd0, 8'd3);
      feed($urandom, 0);
      scnt = 0;
      while (!bus_wen && scnt < 20) begin
         step();
         scnt++;
      end
      chk("mid_strobe_seen", bus_wen, 1);
      #3;
      nReset = 0;
      #1;
      chk("mid_rst_wen", bus_wen, 0);
      chk("mid_rst_ren", bus_ren, 0);
      chk("mid_rst_addr", bus_addr, 32'(BASE));
      chk("mid_rst_wdata", bus_wdata, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", err, 0);
      step();
      nReset = 1;
      step();
      send_cmd(0, 3'd2, 8'd0);
      dcnt = 0; scnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         dcnt += int'(done);
         scnt += int'(bus_ren | bus_wen);
      end
      chk("zero_cnt_extra_done", dcnt, 0);
      chk("zero_cnt_no_strobe", scnt, 0);
      chk("zero_cnt_idle", cmd_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
